mem_bus_ctl: RTL
================

# mem_bus_ctl

Load/store sequencer sitting directly downstream of the MMU. It accepts a memory request from the CPU in the same cycle the MMU latches the virtual address, then consumes the MMU's translation result (physical address, I/O flag, exception) one cycle later. It performs alignment checking, drives the data bus handshake with byte enables, and returns extended load data or an exception code to the CPU.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, bus wait cycles before a bus error is raised (only with watchdog compiled in)

Ports:
- clk  in  1  clock
- res  in  1  synchronous active-high reset
- req  in  1  CPU request strobe; also drives MMU addrValid
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word; 3 reserved (treated as word)
- req_signed  in  1  sign-extend loads
- req_wdata  in  32  store data, right-aligned
- mmu_pAddr  in  32  MMU translated address, valid the cycle after req
- mmu_io  in  1  MMU db_io flag
- mmu_exc  in  `MMU_EXCEPTION  MMU exception code
- bus_req  out  1  bus transaction request
- bus_we  out  1  bus write
- bus_io  out  1  I/O space
- bus_addr  out  32  word address, low 2 bits zero
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian)
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ready
- bus_ready  in  1  transaction complete
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid with done
- exc  out  3  0 none, 1 TLBL, 2 TLBS, 3 TLBMOD, 4 ADEL, 5 ADES, 6 BUSERR; valid with done

## Operation
- States: IDLE, XLATE, BUS, DONE.
- IDLE: on req, latch write/size/signed/wdata → XLATE. busy high from next cycle.
- XLATE: sample mmu_pAddr/mmu_io/mmu_exc. Priority: misalignment (half with addr[0]≠0, word with addr[1:0]≠0) → exc ADEL/ADES; else MMU exception mapped TLBL→1, TLBS→2, TLBMODIFIED→3; any exception → DONE without bus activity. Otherwise → BUS.
- BUS: bus_req held high, address/be/wdata/we/io stable until bus_ready sampled high; then capture bus_rdata → DONE.
- DONE: done=1 for one cycle, rdata/exc held; → IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{b}}, half {2{h}}, word as-is.
- Load: select lane by addr[1:0]; zero- or sign-extend per req_signed; word unchanged. Stores return rdata=0.
- req while busy ignored (no queueing).

## Timing
- Reset (synchronous): state IDLE; busy, done, bus_req, bus_we, bus_io = 0; bus_addr, bus_be, bus_wdata, rdata = 0; exc = 0.
- req at cycle 0 → XLATE cycle 1 → bus_req rises cycle 2 (earliest) → bus_ready at cycle N → done at N+1. Zero-wait bus: done at cycle 3.
- Exception path: done with exc at cycle 2; bus_req never asserted.
- bus_ready outside BUS ignored.
- Reset mid-BUS: bus_req drops the cycle after res sampled; no done pulse.
- done and a new req in the same cycle: req accepted (state leaves DONE to XLATE).

## Configuration
- MEM_BUS_CTL_TIMEOUT_EN defined: 8-bit counter cleared on BUS entry, increments each BUS cycle without bus_ready; when it reaches TIMEOUT_CYCLES, drop bus_req, exc=6 (BUSERR), → DONE. bus_ready on the same cycle as the limit wins (normal completion).
- Undefined: no counter; BUS waits indefinitely; exc never 6.

## Test plan
- Word load, pAddr 0x00001000, bus_ready 1 cycle after bus_req, rdata 0x89ABCDEF → bus_be 4'b1111, done at cycle 4, rdata 0x89ABCDEF, exc 0.
- Signed byte load at pAddr ...03, bus_rdata 0x80FFFFFF → bus_be 4'b1000, rdata 0xFFFFFF80; unsigned → 0x00000080.
- Half store 0x1234 at pAddr ...02 → bus_we 1, bus_be 4'b1100, bus_wdata 0x12341234.
- Word load at pAddr ...02 with mmu_exc TLBL → exc 4 (ADEL), done at cycle 2, bus_req never high; aligned with TLBS on store → exc 2.
- With MEM_BUS_CTL_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready never asserted → bus_req drops after 4 BUS cycles, done with exc 6.
- res asserted during BUS wait → bus_req 0 next cycle, busy 0, no done; subsequent req completes normally.

Source files
------------

// File: rtl/mem_bus_ctl.sv
// Load/store sequencer between MMU and data bus: alignment check, bus handshake, load extension.
// Optional bus watchdog compiled in with MEM_BUS_CTL_TIMEOUT_EN.
`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION 1:0
`endif

module mem_bus_ctl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           mmu_pAddr,
    input  logic                  mmu_io,
    input  logic [`MMU_EXCEPTION] mmu_exc,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic                  bus_io,
    output logic [31:0]           bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic [2:0]            exc
);
    typedef enum logic [1:0] {IDLE, XLATE, BUS, DONE} state_t;

    localparam logic [2:0] EXC_NONE = 3'd0, EXC_TLBL = 3'd1, EXC_TLBS = 3'd2,
                           EXC_TLBMOD = 3'd3, EXC_ADEL = 3'd4, EXC_ADES = 3'd5;
    localparam logic [`MMU_EXCEPTION] MMU_TLBL = 1, MMU_TLBS = 2, MMU_TLBMOD = 3;

    state_t      state_q, state_d;
    logic        write_q, write_d, signed_q, signed_d;
    logic [1:0]  size_q, size_d, addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_we_q, bus_we_d, bus_io_q, bus_io_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  exc_q, exc_d;

    logic        misalign;
    logic [2:0]  mmu_code;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

`ifdef MEM_BUS_CTL_TIMEOUT_EN
    localparam logic [2:0] EXC_BUSERR = 3'd6;
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        misalign = 1'b0;
        case (size_q)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = mmu_pAddr[0];
            default: misalign = |mmu_pAddr[1:0];
        endcase
        case (mmu_exc)
            MMU_TLBL:   mmu_code = EXC_TLBL;
            MMU_TLBS:   mmu_code = EXC_TLBS;
            MMU_TLBMOD: mmu_code = EXC_TLBMOD;
            default:    mmu_code = EXC_NONE;
        endcase
        // Lane extraction uses the latched low address bits; bus_addr is word aligned.
        lane_b = bus_rdata[{addr_lo_q, 3'b000} +: 8];
        lane_h = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
            2'd1:    load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        bus_we_d    = bus_we_q;
        bus_io_d    = bus_io_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        exc_d       = exc_q;
`ifdef MEM_BUS_CTL_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    size_d   = req_size;
                    wdata_d  = req_wdata;
                    state_d  = XLATE;
                end
            end
            XLATE: begin
                if (misalign || mmu_code != EXC_NONE) begin
                    exc_d   = misalign ? (write_q ? EXC_ADES : EXC_ADEL) : mmu_code;
                    rdata_d = 32'd0;
                    state_d = DONE;
                end else begin
                    addr_lo_d  = mmu_pAddr[1:0];
                    bus_addr_d = {mmu_pAddr[31:2], 2'b00};
                    bus_we_d   = write_q;
                    bus_io_d   = mmu_io;
                    case (size_q)
                        2'd0: begin
                            bus_be_d    = 4'b0001 << mmu_pAddr[1:0];
                            bus_wdata_d = {4{wdata_q[7:0]}};
                        end
                        2'd1: begin
                            bus_be_d    = 4'b0011 << mmu_pAddr[1:0];
                            bus_wdata_d = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            bus_be_d    = 4'b1111;
                            bus_wdata_d = wdata_q;
                        end
                    endcase
`ifdef MEM_BUS_CTL_TIMEOUT_EN
                    cnt_d = 8'd0;
`endif
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus_ready) begin
                    rdata_d = write_q ? 32'd0 : load_ext;
                    exc_d   = EXC_NONE;
                    state_d = DONE;
                end
`ifdef MEM_BUS_CTL_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CYCLES[7:0]) begin
                        rdata_d = 32'd0;
                        exc_d   = EXC_BUSERR;
                        state_d = DONE;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'd0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= 32'd0;
            bus_we_q    <= 1'b0;
            bus_io_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            rdata_q     <= 32'd0;
            exc_q       <= 3'd0;
`ifdef MEM_BUS_CTL_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            bus_we_q    <= bus_we_d;
            bus_io_q    <= bus_io_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rdata_q     <= rdata_d;
            exc_q       <= exc_d;
`ifdef MEM_BUS_CTL_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus_req   = (state_q == BUS);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign bus_we    = bus_we_q;
    assign bus_io    = bus_io_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rdata     = rdata_q;
    assign exc       = exc_q;
endmodule
